// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data RAM between the CPU memory stage and the debug/loader port.
// The CPU has fixed priority; debug is guaranteed service after MAX_WAIT blocked cycles.
module dmem_arbiter #(
    parameter int REG_WIDTH    = 32,
    parameter int NUM_MEM_LOCS = 256,
    parameter int ADDR_BITS    = $clog2(NUM_MEM_LOCS),
    parameter int MAX_WAIT     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [REG_WIDTH-1:0] cpu_wdata,
    output logic [REG_WIDTH-1:0] cpu_rdata,
    output logic                 cpu_stall,
    input  logic                 dbg_req,
    input  logic                 dbg_we,
    input  logic [ADDR_BITS-1:0] dbg_addr,
    input  logic [REG_WIDTH-1:0] dbg_wdata,
    output logic                 dbg_ack,
    output logic [REG_WIDTH-1:0] dbg_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [REG_WIDTH-1:0] mem_wdata,
    input  logic [REG_WIDTH-1:0] mem_rdata,
    output logic [15:0]          stall_count
);

    localparam int WAIT_BITS = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_BITS-1:0] WAIT_LIMIT = WAIT_BITS'(MAX_WAIT);

    typedef enum logic {
        IDLE,
        DBG_ACK
    } state_t;

    state_t               state, state_next;
    logic [WAIT_BITS-1:0] wait_cnt, wait_cnt_next;

    assign cpu_rdata = mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            stall_count <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (cpu_stall && stall_count != 16'hFFFF) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

    // Outputs are gated by rst so the RAM and both requesters see a quiet bus during reset.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        cpu_stall     = 1'b0;
        dbg_ack       = 1'b0;
        dbg_rdata     = '0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (dbg_req && (!cpu_req || wait_cnt == WAIT_LIMIT)) begin
                        mem_en        = 1'b1;
                        mem_we        = dbg_we;
                        mem_addr      = dbg_addr;
                        mem_wdata     = dbg_wdata;
                        cpu_stall     = cpu_req;
                        state_next    = DBG_ACK;
                        wait_cnt_next = '0;
                    end else if (cpu_req) begin
                        mem_en    = 1'b1;
                        mem_we    = cpu_we;
                        mem_addr  = cpu_addr;
                        mem_wdata = cpu_wdata;
                        if (dbg_req && wait_cnt != WAIT_LIMIT) begin
                            wait_cnt_next = wait_cnt + 1'b1;
                        end
                    end
                end
                DBG_ACK: begin
                    // dbg_req is deliberately ignored here so debug can never be granted twice in a row.
                    dbg_ack    = 1'b1;
                    dbg_rdata  = mem_rdata;
                    state_next = IDLE;
                    if (cpu_req) begin
                        mem_en    = 1'b1;
                        mem_we    = cpu_we;
                        mem_addr  = cpu_addr;
                        mem_wdata = cpu_wdata;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus queues expected acks, stalls and read data,
// and an independent monitor compares them against what the DUT presents each cycle.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [7:0]  dbg_addr = '0;
    logic [31:0] dbg_wdata = '0;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [15:0] stall_count;

    typedef struct {
        int          cycle;
        logic [31:0] data;
        bit          check_data;
    } dbg_exp_t;

    dbg_exp_t    dbg_q[$];
    int          stall_q[$];
    logic [31:0] cpu_q[$];
    logic [31:0] ram [0:255];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    dmem_arbiter #(
        .REG_WIDTH(32), .NUM_MEM_LOCS(256), .ADDR_BITS(8), .MAX_WAIT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM with one-cycle read latency, read-before-write.
    initial for (int i = 0; i < 256; i++) ram[i] = '0;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic cr, input logic cw, input logic [7:0] ca, input logic [31:0] cd,
                                 input logic dr, input logic dw, input logic [7:0] da, input logic [31:0] dd);
        @(posedge clk);
        #1;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    endtask

    task automatic contendRound(input logic [15:0] exp_count);
        int n;
        applyStimulus(1, 1, 8'd20, 32'hAAAA5555, 1, 0, 8'd3, 32'h0);
        n = cyc;
        stall_q.push_back(n + 4);
        dbg_q.push_back(dbg_exp_t'{n + 5, 32'h12345678, 1'b1});
        repeat (4) applyStimulus(1, 1, 8'd20, 32'hAAAA5555, 1, 0, 8'd3, 32'h0);
        applyStimulus(1, 1, 8'd20, 32'hAAAA5555, 0, 0, 8'd0, 32'h0);
        #1;
        checkOutput("cpu_served_in_ack_stall", 32'(cpu_stall), 32'd0);
        checkOutput("cpu_served_in_ack_en", 32'(mem_en), 32'd1);
        checkOutput("cpu_served_in_ack_addr", 32'(mem_addr), 32'd20);
        checkOutput("stall_count_round", 32'(stall_count), 32'(exp_count));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        checkOutput({tag, "_cpu_stall"}, 32'(cpu_stall), 32'd0);
        checkOutput({tag, "_dbg_ack"}, 32'(dbg_ack), 32'd0);
        checkOutput({tag, "_dbg_rdata"}, dbg_rdata, 32'd0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows an ack, a stall or a granted CPU access.
    initial begin
        logic     pending_read;
        logic     prev_ack;
        dbg_exp_t e;
        pending_read = 1'b0;
        prev_ack     = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pending_read = 1'b0;
                prev_ack     = 1'b0;
            end else begin
                if (pending_read) begin
                    if (cpu_q.size() == 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL cpu_read_unexpected: got %h, expected no read (cycle %0d)", cpu_rdata, cyc);
                    end else begin
                        checkOutput("cpu_rdata", cpu_rdata, cpu_q.pop_front());
                    end
                end
                pending_read = cpu_req && !cpu_we && !cpu_stall;
                if (cpu_req && !cpu_stall) begin
                    checkOutput("cpu_grant_en", 32'(mem_en), 32'd1);
                    checkOutput("cpu_grant_we", 32'(mem_we), 32'(cpu_we));
                    checkOutput("cpu_grant_addr", 32'(mem_addr), 32'(cpu_addr));
                    if (cpu_we) checkOutput("cpu_grant_wdata", mem_wdata, cpu_wdata);
                end
                if (cpu_stall) begin
                    checkOutput("stall_needs_req", 32'(cpu_req), 32'd1);
                    if (stall_q.size() == 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL stall_unexpected: got stall at cycle %0d, expected none", cyc);
                    end else begin
                        checkOutput("stall_cycle", 32'(cyc), 32'(stall_q.pop_front()));
                    end
                end
                if (dbg_ack) begin
                    checkOutput("ack_not_consecutive", 32'(prev_ack), 32'd0);
                    if (dbg_q.size() == 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL ack_unexpected: got ack at cycle %0d, expected none", cyc);
                    end else begin
                        e = dbg_q.pop_front();
                        checkOutput("ack_cycle", 32'(cyc), 32'(e.cycle));
                        if (e.check_data) checkOutput("dbg_rdata", dbg_rdata, e.data);
                    end
                end else begin
                    checkOutput("dbg_rdata_idle", dbg_rdata, 32'd0);
                end
                prev_ack = dbg_ack;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        // Reset held with a CPU request pending: the bus must stay quiet.
        cpu_req = 1'b1;
        #12;
        checkAllZero("in_reset");
        checkOutput("in_reset_stall_count", 32'(stall_count), 32'd0);
        cpu_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Asynchronous reset mid-cycle while the CPU is being granted.
        applyStimulus(1, 0, 8'd5, 32'h0, 0, 0, 8'd0, 32'h0);
        #1 checkOutput("pre_reset_grant", 32'(mem_en), 32'd1);
        #1 rst = 1'b1;
        #1 checkAllZero("async_reset");
        cpu_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("after_reset_stall_count", 32'(stall_count), 32'd0);

        // CPU only: write then read back.
        applyStimulus(1, 1, 8'd8, 32'hDEADBEEF, 0, 0, 8'd0, 32'h0);
        #1 checkOutput("cpu_write_we", 32'(mem_we), 32'd1);
        applyStimulus(1, 0, 8'd8, 32'h0, 0, 0, 8'd0, 32'h0);
        cpu_q.push_back(32'hDEADBEEF);
        applyStimulus(0, 0, 8'd0, 32'h0, 0, 0, 8'd0, 32'h0);
        applyStimulus(0, 0, 8'd0, 32'h0, 0, 0, 8'd0, 32'h0);

        // Debug only: write then read back, each acked one cycle later.
        applyStimulus(0, 0, 8'd0, 32'h0, 1, 1, 8'd3, 32'h12345678);
        dbg_q.push_back(dbg_exp_t'{cyc + 1, 32'h0, 1'b0});
        applyStimulus(0, 0, 8'd0, 32'h0, 0, 0, 8'd0, 32'h0);
        applyStimulus(0, 0, 8'd0, 32'h0, 1, 0, 8'd3, 32'h0);
        dbg_q.push_back(dbg_exp_t'{cyc + 1, 32'h12345678, 1'b1});
        applyStimulus(0, 0, 8'd0, 32'h0, 0, 0, 8'd0, 32'h0);
        applyStimulus(0, 0, 8'd0, 32'h0, 0, 0, 8'd0, 32'h0);

        // Contention with a continuously requesting CPU.
        applyStimulus(1, 1, 8'd20, 32'hAAAA5555, 0, 0, 8'd0, 32'h0);
        contendRound(16'd1);

        // Blocked count survives a dropped request: 2 blocked, drop, then 2 more before the grant.
        applyStimulus(1, 1, 8'd20, 32'hAAAA5555, 1, 0, 8'd3, 32'h0);
        applyStimulus(1, 1, 8'd20, 32'hAAAA5555, 1, 0, 8'd3, 32'h0);
        repeat (3) applyStimulus(1, 1, 8'd20, 32'hAAAA5555, 0, 0, 8'd0, 32'h0);
        applyStimulus(1, 1, 8'd20, 32'hAAAA5555, 1, 0, 8'd3, 32'h0);
        n = cyc;
        stall_q.push_back(n + 2);
        dbg_q.push_back(dbg_exp_t'{n + 3, 32'h12345678, 1'b1});
        repeat (2) applyStimulus(1, 1, 8'd20, 32'hAAAA5555, 1, 0, 8'd3, 32'h0);
        applyStimulus(1, 1, 8'd20, 32'hAAAA5555, 0, 0, 8'd0, 32'h0);
        applyStimulus(0, 0, 8'd0, 32'h0, 0, 0, 8'd0, 32'h0);
        #1 checkOutput("stall_count_hold", 32'(stall_count), 32'd2);

        // Back-to-back debug: request held through the ack is granted at N and N+2 only.
        applyStimulus(0, 0, 8'd0, 32'h0, 1, 0, 8'd3, 32'h0);
        n = cyc;
        dbg_q.push_back(dbg_exp_t'{n + 1, 32'h12345678, 1'b1});
        dbg_q.push_back(dbg_exp_t'{n + 3, 32'h12345678, 1'b1});
        repeat (3) applyStimulus(0, 0, 8'd0, 32'h0, 1, 0, 8'd3, 32'h0);
        applyStimulus(0, 0, 8'd0, 32'h0, 0, 0, 8'd0, 32'h0);
        applyStimulus(0, 0, 8'd0, 32'h0, 0, 0, 8'd0, 32'h0);

        // Saturation: preload the counter near the top instead of spending 65k real stalls.
        @(negedge clk);
        force dut.stall_count = 16'hFFFC;
        #1 release dut.stall_count;
        #1 checkOutput("stall_count_preload", 32'(stall_count), 32'h0000FFFC);
        applyStimulus(1, 1, 8'd20, 32'hAAAA5555, 0, 0, 8'd0, 32'h0);
        contendRound(16'hFFFD);
        contendRound(16'hFFFE);
        contendRound(16'hFFFF);
        contendRound(16'hFFFF);
        contendRound(16'hFFFF);
        applyStimulus(0, 0, 8'd0, 32'h0, 0, 0, 8'd0, 32'h0);
        applyStimulus(0, 0, 8'd0, 32'h0, 0, 0, 8'd0, 32'h0);

        // Reset while in the ack state swallows the ack.
        applyStimulus(0, 0, 8'd0, 32'h0, 1, 0, 8'd3, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        dbg_req = 1'b0;
        #1 checkOutput("reset_in_ack_dbg_ack", 32'(dbg_ack), 32'd0);
        checkOutput("reset_in_ack_dbg_rdata", dbg_rdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset_in_ack_stall_count", 32'(stall_count), 32'd0);
        repeat (3) applyStimulus(0, 0, 8'd0, 32'h0, 0, 0, 8'd0, 32'h0);

        // Anything still queued was never delivered by the DUT.
        @(negedge clk);
        #1;
        checkOutput("dbg_q_drained", 32'(dbg_q.size()), 32'd0);
        checkOutput("stall_q_drained", 32'(stall_q.size()), 32'd0);
        checkOutput("cpu_q_drained", 32'(cpu_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single synchronous data memory between the pipeline's memory stage (CPU port) and an external debug/loader port. The CPU has fixed priority. Debug gets a bounded wait: after MAX_WAIT consecutive blocked cycles, it forces a one-cycle CPU stall. The block sits between the memory stage, the data RAM and the FPGA debug interface. It also keeps a saturating count of stall cycles it has inflicted on the pipeline.

## Interface
- REG_WIDTH, 32, data word width
- NUM_MEM_LOCS, 256, memory depth in words
- ADDR_BITS, $clog2(NUM_MEM_LOCS), word address width
- MAX_WAIT, 4, blocked debug cycles before the CPU is forced to stall (≥1)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- cpu_req / cpu_we  in  1 / 1  memory-stage access request / write enable
- cpu_addr / cpu_wdata  in  ADDR_BITS / REG_WIDTH  CPU address / store data
- cpu_rdata  out  REG_WIDTH  load data, valid the cycle after a granted CPU read
- cpu_stall  out  1  pipeline must hold the memory stage this cycle
- dbg_req / dbg_we  in  1 / 1  debug request (level, held until ack) / write enable
- dbg_addr / dbg_wdata  in  ADDR_BITS / REG_WIDTH  debug address / write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  REG_WIDTH  read data, valid only while dbg_ack=1, else 0
- mem_en / mem_we  out  1 / 1  RAM enable / write enable
- mem_addr / mem_wdata  out  ADDR_BITS / REG_WIDTH  RAM address / write data
- mem_rdata  in  REG_WIDTH  RAM read data, 1-cycle latency after mem_en
- stall_count  out  16  saturating count of cycles with cpu_stall=1

## Operation
- State: FSM {IDLE, DBG_ACK}, wait_cnt (0..MAX_WAIT), stall_count.
- **IDLE, debug issue:** if dbg_req && (!cpu_req || wait_cnt==MAX_WAIT):
  - drive the RAM from the debug port: mem_en=1, mem_we=dbg_we.
  - cpu_stall=cpu_req.
  - next state DBG_ACK, wait_cnt←0.
- **IDLE, CPU access:** else if cpu_req:
  - drive the RAM from the CPU port: mem_en=1, mem_we=cpu_we, cpu_stall=0.
  - if dbg_req, wait_cnt←wait_cnt+1, saturating at MAX_WAIT.
- **IDLE, nothing:** otherwise mem_en=0, and mem_addr/mem_wdata/mem_we are driven 0.
- **DBG_ACK:**
  - dbg_ack=1, dbg_rdata=mem_rdata (write ack returns data unchanged from RAM, don't-care to requester).
  - The CPU may access in the same cycle, with no stall.
  - dbg_req is ignored in this state, so back-to-back debug grants are impossible.
  - Next state is IDLE. The requester must drop dbg_req on ack; if dbg_req is still high in IDLE, it is a new request.
- cpu_rdata = mem_rdata, passed through unregistered. The pipeline samples it only the cycle after its own granted read.
- stall_count increments on every cycle with cpu_stall=1 and saturates at 16'hFFFF.
- A stalled CPU request must be held stable by the pipeline; it is served in the next cycle (DBG_ACK).

## Timing
- **Reset values:** while rst=1 or on reset exit:
  - state IDLE, wait_cnt 0, stall_count 0.
  - mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0.
  - cpu_stall 0, dbg_ack 0, dbg_rdata 0.
- **Reset mid-operation:** reset asserted in DBG_ACK aborts the ack (no pulse); the debug side re-requests.
- **CPU latency:** grant is combinational in the request cycle. Read data arrives on cycle N+1.
- **Debug latency:**
  - With the CPU idle, dbg_req at cycle N gives dbg_ack at N+1.
  - With the CPU continuously requesting, dbg_ack arrives at N+MAX_WAIT+1, with exactly one CPU stall cycle at N+MAX_WAIT.
- **Simultaneous requests, wait_cnt<MAX_WAIT:** CPU wins and no stall occurs.
- **Simultaneous requests, wait_cnt==MAX_WAIT:** debug wins and the CPU stalls 1 cycle.
- wait_cnt holds its value (does not clear) when dbg_req drops without a grant.

## Test plan
- **Reset:** assert rst asynchronously mid-cycle → all outputs 0 immediately, and stall_count=0 after release.
- **CPU only:** write 32'hDEADBEEF @addr 8, then read addr 8 → mem_we=1 in the write cycle; cpu_rdata=32'hDEADBEEF one cycle after the read grant; cpu_stall never 1.
- **Debug only:** dbg write 32'h12345678 @addr 3, then dbg read addr 3 → each dbg_ack 1 cycle after request; dbg_rdata=32'h12345678 during the read ack, 0 otherwise.
- **Contention:** cpu_req held high continuously, dbg_req raised at cycle 10, MAX_WAIT=4:
  - cpu_stall=1 only at cycle 14.
  - dbg_ack at 15.
  - CPU served at 15.
  - stall_count=1.
- **Back-to-back debug:** dbg_req held high through the ack → grants at N and N+2, never N+1; dbg_ack never high on two consecutive cycles.
- **Saturation:** force 65,540 stall cycles (repeated contention) → stall_count stays 16'hFFFF; reset mid-DBG_ACK → no dbg_ack pulse.
